qcl_breath_multi: RTL and testbench

- Multi-channel successor to the single-channel fixed-period breath toggler.
- Each of els_p channels counts its own enable events and toggles its output at the end of each phase.
- High and low phase lengths are independently runtime-programmable per channel; each channel also has a selectable output mode (square or strobe).
- Sits beside status LEDs / heartbeat logic; software reprograms channels through a simple config write port.
- Config writes take effect glitch-free at the next phase boundary.

---
 rtl/qcl_breath_multi.sv | 80 ++++++++
 tb/tb_qcl_breath_multi.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/qcl_breath_multi.sv
// Multi-channel breath toggler: each channel counts enable events and toggles its
// phase level after a programmable number of events per high/low phase.
module qcl_breath_multi #(
  parameter int                  els_p        = 4,
  parameter int                  width_p      = 24,
  parameter logic [width_p-1:0]  hi_default_p = width_p'(10_000_000),
  parameter logic [width_p-1:0]  lo_default_p = hi_default_p,
  localparam int                 ch_w_lp      = (els_p == 1) ? 1 : $clog2(els_p)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [els_p-1:0]    en_i,
  input  logic                cfg_v_i,
  input  logic [ch_w_lp-1:0]  cfg_ch_i,
  input  logic [width_p-1:0]  cfg_hi_i,
  input  logic [width_p-1:0]  cfg_lo_i,
  input  logic                cfg_mode_i,
  output logic [els_p-1:0]    o,
  output logic [els_p-1:0]    level_o,
  output logic [els_p-1:0]    edge_o
);

  for (genvar i = 0; i < els_p; i++) begin : g_ch
    logic [width_p-1:0] count_r;
    logic [width_p-1:0] hi_r, lo_r, hi_s, lo_s;
    logic [width_p-1:0] limit;
    logic               level_r, edge_r, mode_r, mode_s, pend_r;
    logic               wr, boundary;

    // Out-of-range channel numbers never match any index, so those writes drop out.
    assign wr       = cfg_v_i && (cfg_ch_i == ch_w_lp'(i));
    assign limit    = level_r ? hi_r : lo_r;
    assign boundary = en_i[i] && (count_r == limit);

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        count_r <= '0;
        level_r <= 1'b0;
        edge_r  <= 1'b0;
        pend_r  <= 1'b0;
        hi_r    <= hi_default_p;
        lo_r    <= lo_default_p;
        mode_r  <= 1'b0;
        hi_s    <= hi_default_p;
        lo_s    <= lo_default_p;
        mode_s  <= 1'b0;
      end else begin
        edge_r <= boundary;
        if (wr) begin
          hi_s   <= cfg_hi_i;
          lo_s   <= cfg_lo_i;
          mode_s <= cfg_mode_i;
        end
        if (boundary) begin
          count_r <= '0;
          level_r <= ~level_r;
          pend_r  <= 1'b0;
          // A write landing on the boundary itself governs the phase that starts now.
          if (wr) begin
            hi_r   <= cfg_hi_i;
            lo_r   <= cfg_lo_i;
            mode_r <= cfg_mode_i;
          end else if (pend_r) begin
            hi_r   <= hi_s;
            lo_r   <= lo_s;
            mode_r <= mode_s;
          end
        end else begin
          if (en_i[i]) count_r <= count_r + width_p'(1);
          if (wr)      pend_r  <= 1'b1;
        end
      end
    end

    assign level_o[i] = level_r;
    assign edge_o[i]  = edge_r;
    assign o[i]       = mode_r ? (edge_r & level_r) : level_r;
  end

endmodule

// File: tb/tb_qcl_breath_multi.sv
// Directed bench for qcl_breath_multi with 5 channels, 4-bit fields, defaults hi=lo=2.
module tb_qcl_breath_multi;

  localparam int els_p   = 5;
  localparam int width_p = 4;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic [4:0]       en_i;
  logic             cfg_v_i;
  logic [2:0]       cfg_ch_i;
  logic [3:0]       cfg_hi_i, cfg_lo_i;
  logic             cfg_mode_i;
  logic [4:0]       o, level_o, edge_o;

  int checks = 0;
  int errors = 0;

  qcl_breath_multi #(
    .els_p(els_p), .width_p(width_p), .hi_default_p(4'd2), .lo_default_p(4'd2)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .cfg_v_i(cfg_v_i),
    .cfg_ch_i(cfg_ch_i), .cfg_hi_i(cfg_hi_i), .cfg_lo_i(cfg_lo_i),
    .cfg_mode_i(cfg_mode_i), .o(o), .level_o(level_o), .edge_o(edge_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0] en;
    logic       v;
    logic [2:0] ch;
    logic [3:0] hi;
    logic [3:0] lo;
    logic       m;
    logic [4:0] lvl;
    logic [4:0] edg;
    logic [4:0] o;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [4:0] en, input logic v, input logic [2:0] ch,
                     input logic [3:0] hi, input logic [3:0] lo, input logic m,
                     input logic [4:0] lvl, input logic [4:0] edg, input logic [4:0] ov);
    vec_t r;
    r.en = en; r.v = v; r.ch = ch; r.hi = hi; r.lo = lo; r.m = m;
    r.lvl = lvl; r.edg = edg; r.o = ov;
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Inputs are driven 1 time unit after a rising edge; outputs are sampled 1 unit after the next.
  task automatic cyc(input string name, input logic [4:0] en, input logic v,
                     input logic [2:0] ch, input logic [3:0] hi, input logic [3:0] lo,
                     input logic m, input logic [4:0] lvl, input logic [4:0] edg,
                     input logic [4:0] ov);
    en_i = en; cfg_v_i = v; cfg_ch_i = ch; cfg_hi_i = hi; cfg_lo_i = lo; cfg_mode_i = m;
    @(posedge clk_i); #1;
    chk({name, " level"}, level_o, lvl);
    chk({name, " edge"},  edge_o,  edg);
    chk({name, " o"},     o,       ov);
  endtask

  task automatic do_reset();
    reset_i = 1'b1; en_i = '0; cfg_v_i = 1'b0;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; en_i = '0; cfg_v_i = 1'b0; cfg_ch_i = '0;
    cfg_hi_i = '0; cfg_lo_i = '0; cfg_mode_i = 1'b0;
    @(posedge clk_i); #1;
    chk("reset level", level_o, 5'b0);
    chk("reset edge",  edge_o,  5'b0);
    chk("reset o",     o,       5'b0);
    reset_i = 1'b0;
    cyc("idle", 5'b0, 0, 0, 0, 0, 0, 5'b0, 5'b0, 5'b0);

    // ch0 held enabled with default lengths: low 3, high 3
    add(5'b00001, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000);
    add(5'b00001, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000);
    add(5'b00001, 0, 0, 0, 0, 0, 5'b00001, 5'b00001, 5'b00001);
    add(5'b00001, 0, 0, 0, 0, 0, 5'b00001, 5'b00000, 5'b00001);
    add(5'b00001, 0, 0, 0, 0, 0, 5'b00001, 5'b00000, 5'b00001);
    add(5'b00001, 0, 0, 0, 0, 0, 5'b00000, 5'b00001, 5'b00000);
    add(5'b00001, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000);
    add(5'b00001, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000);
    add(5'b00001, 0, 0, 0, 0, 0, 5'b00001, 5'b00001, 5'b00001);
    // ch1 gets hi=lo=0 (pending), finishes its default low phase, then toggles per enable
    add(5'b00000, 1, 1, 0, 0, 0, 5'b00001, 5'b00000, 5'b00001);
    add(5'b00010, 0, 0, 0, 0, 0, 5'b00001, 5'b00000, 5'b00001);
    add(5'b00010, 0, 0, 0, 0, 0, 5'b00001, 5'b00000, 5'b00001);
    add(5'b00010, 0, 0, 0, 0, 0, 5'b00011, 5'b00010, 5'b00011);
    add(5'b00000, 0, 0, 0, 0, 0, 5'b00011, 5'b00000, 5'b00011);
    add(5'b00000, 0, 0, 0, 0, 0, 5'b00011, 5'b00000, 5'b00011);
    add(5'b00010, 0, 0, 0, 0, 0, 5'b00001, 5'b00010, 5'b00001);
    add(5'b00000, 0, 0, 0, 0, 0, 5'b00001, 5'b00000, 5'b00001);
    add(5'b00000, 0, 0, 0, 0, 0, 5'b00001, 5'b00000, 5'b00001);
    add(5'b00010, 0, 0, 0, 0, 0, 5'b00011, 5'b00010, 5'b00011);
    add(5'b00000, 0, 0, 0, 0, 0, 5'b00011, 5'b00000, 5'b00011);

    for (int k = 0; k < tbl.size(); k++)
      cyc($sformatf("tbl%0d", k), tbl[k].en, tbl[k].v, tbl[k].ch, tbl[k].hi,
          tbl[k].lo, tbl[k].m, tbl[k].lvl, tbl[k].edg, tbl[k].o);

    // ch2: reprogram mid low phase; the old length still finishes the phase
    do_reset();
    cyc("c2s1",  5'b00100, 1, 2, 0, 5, 0, 5'b00000, 5'b00000, 5'b00000);
    cyc("c2s2",  5'b00100, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000);
    cyc("c2s3",  5'b00100, 0, 0, 0, 0, 0, 5'b00100, 5'b00100, 5'b00100);
    cyc("c2s4",  5'b00100, 0, 0, 0, 0, 0, 5'b00000, 5'b00100, 5'b00000);
    cyc("c2s5",  5'b00100, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000);
    cyc("c2s6",  5'b00100, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000);
    cyc("c2s7",  5'b00000, 1, 2, 1, 0, 0, 5'b00000, 5'b00000, 5'b00000);
    cyc("c2s8",  5'b00100, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000);
    cyc("c2s9",  5'b00100, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000);
    cyc("c2s10", 5'b00100, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000);
    cyc("c2s11", 5'b00100, 0, 0, 0, 0, 0, 5'b00100, 5'b00100, 5'b00100);
    cyc("c2s12", 5'b00100, 0, 0, 0, 0, 0, 5'b00100, 5'b00000, 5'b00100);
    cyc("c2s13", 5'b00100, 0, 0, 0, 0, 0, 5'b00000, 5'b00100, 5'b00000);
    cyc("c2s14", 5'b00100, 0, 0, 0, 0, 0, 5'b00100, 5'b00100, 5'b00100);

    // ch0: write on the boundary cycle governs the very next phase
    do_reset();
    cyc("c0t1",  5'b00001, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000);
    cyc("c0t2",  5'b00001, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000);
    cyc("c0t3",  5'b00001, 0, 0, 0, 0, 0, 5'b00001, 5'b00001, 5'b00001);
    cyc("c0t4",  5'b00001, 0, 0, 0, 0, 0, 5'b00001, 5'b00000, 5'b00001);
    cyc("c0t5",  5'b00001, 0, 0, 0, 0, 0, 5'b00001, 5'b00000, 5'b00001);
    cyc("c0t6",  5'b00001, 1, 0, 2, 3, 0, 5'b00000, 5'b00001, 5'b00000);
    cyc("c0t7",  5'b00001, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000);
    cyc("c0t8",  5'b00001, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000);
    cyc("c0t9",  5'b00001, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000);
    cyc("c0t10", 5'b00001, 0, 0, 0, 0, 0, 5'b00001, 5'b00001, 5'b00001);
    cyc("c0t11", 5'b00001, 0, 0, 0, 0, 0, 5'b00001, 5'b00000, 5'b00001);

    // ch3 strobe mode, hi=lo=1: o pulses only on rising toggles
    do_reset();
    cyc("c3t1",  5'b01000, 1, 3, 1, 1, 1, 5'b00000, 5'b00000, 5'b00000);
    cyc("c3t2",  5'b01000, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000);
    cyc("c3t3",  5'b01000, 0, 0, 0, 0, 0, 5'b01000, 5'b01000, 5'b01000);
    cyc("c3t4",  5'b01000, 0, 0, 0, 0, 0, 5'b01000, 5'b00000, 5'b00000);
    cyc("c3t5",  5'b01000, 0, 0, 0, 0, 0, 5'b00000, 5'b01000, 5'b00000);
    cyc("c3t6",  5'b01000, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000);
    cyc("c3t7",  5'b01000, 0, 0, 0, 0, 0, 5'b01000, 5'b01000, 5'b01000);
    cyc("c3t8",  5'b01000, 0, 0, 0, 0, 0, 5'b01000, 5'b00000, 5'b00000);
    cyc("c3t9",  5'b01000, 0, 0, 0, 0, 0, 5'b00000, 5'b01000, 5'b00000);
    cyc("c3t10", 5'b01000, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000);
    cyc("c3t11", 5'b01000, 0, 0, 0, 0, 0, 5'b01000, 5'b01000, 5'b01000);

    // asynchronous reset mid high phase with a pending config on ch0
    do_reset();
    cyc("rsu1", 5'b00011, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000);
    cyc("rsu2", 5'b00011, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000);
    cyc("rsu3", 5'b00011, 0, 0, 0, 0, 0, 5'b00011, 5'b00011, 5'b00011);
    cyc("rsu4", 5'b00000, 1, 0, 0, 0, 1, 5'b00011, 5'b00000, 5'b00011);
    cyc("rsu5", 5'b00010, 0, 0, 0, 0, 0, 5'b00011, 5'b00000, 5'b00011);
    cyc("rsu6", 5'b00010, 0, 0, 0, 0, 0, 5'b00011, 5'b00000, 5'b00011);
    cyc("rsu7", 5'b00010, 0, 0, 0, 0, 0, 5'b00001, 5'b00010, 5'b00001);
    en_i = '0;
    reset_i = 1'b1;
    #1;
    chk("async level", level_o, 5'b0);
    chk("async edge",  edge_o,  5'b0);
    chk("async o",     o,       5'b0);
    @(posedge clk_i); #1;
    chk("held level", level_o, 5'b0);
    reset_i = 1'b0;
    // defaults on every channel; writes to channels 5..7 must not land anywhere
    cyc("rsv1", 5'b11111, 1, 5, 0, 0, 1, 5'b00000, 5'b00000, 5'b00000);
    cyc("rsv2", 5'b11111, 1, 6, 0, 0, 1, 5'b00000, 5'b00000, 5'b00000);
    cyc("rsv3", 5'b11111, 1, 7, 0, 0, 1, 5'b11111, 5'b11111, 5'b11111);
    cyc("rsv4", 5'b11111, 0, 0, 0, 0, 0, 5'b11111, 5'b00000, 5'b11111);
    cyc("rsv5", 5'b11111, 0, 0, 0, 0, 0, 5'b11111, 5'b00000, 5'b11111);
    cyc("rsv6", 5'b11111, 0, 0, 0, 0, 0, 5'b00000, 5'b11111, 5'b00000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
